except_ctrl: RTL and testbench

EXCEPT_CTRL -- requirements
Module: except_ctrl

---
 rtl/exc_pkg.sv | 48 ++++
 rtl/exc_priority_enc.sv | 37 +++
 rtl/except_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_except_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: cause codes, the
// exception vector, FSM state encoding and interrupt-pending helper.
package exc_pkg;

    // MIPS32 ExcCode values written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // General exception entry point (BEV=1 boot vector + 0x380)
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    // Bit positions inside the raw exception vector from the pipeline
    localparam int EXC_VEC_W      = 6;
    localparam int EXB_ADEL_FETCH = 0;
    localparam int EXB_RI         = 1;
    localparam int EXB_SYS        = 2;
    localparam int EXB_BP         = 3;
    localparam int EXB_OV         = 4;
    localparam int EXB_ADDR_DATA  = 5;

    // Controller sequence: take event, flush pipeline, redirect fetch
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } exc_state_e;

    // What kind of event the current sequence is servicing
    typedef enum logic {
        EV_EXC  = 1'b0,
        EV_ERET = 1'b1
    } event_kind_e;

    // An interrupt is pending when an unmasked IP bit is set, interrupts
    // are globally enabled (IE) and we are not already at exception level.
    function automatic logic int_pending(input logic [7:0] cause_ip,
                                         input logic [7:0] status_im,
                                         input logic       status_ie,
                                         input logic       status_exl);
        return ((cause_ip & status_im) != 8'h00) && status_ie && !status_exl;
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder: picks the single highest-priority
// exception among the interrupt and the raw pipeline exception flags.
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic [EXC_VEC_W-1:0] i_exc_vec,
    input  logic                 i_int_pending,
    input  logic                 i_is_store,
    output logic                 o_valid,
    output logic [4:0]           o_code
);

    // Fixed priority: Int > AdEL-fetch > RI > Sys > Bp > Ov > data address
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_valid = 1'b1;
        o_code  = EXC_INT;
        if (i_int_pending) begin
            o_code = EXC_INT;
        end else if (i_exc_vec[EXB_ADEL_FETCH]) begin
            o_code = EXC_ADEL;
        end else if (i_exc_vec[EXB_RI]) begin
            o_code = EXC_RI;
        end else if (i_exc_vec[EXB_SYS]) begin
            o_code = EXC_SYS;
        end else if (i_exc_vec[EXB_BP]) begin
            o_code = EXC_BP;
        end else if (i_exc_vec[EXB_OV]) begin
            o_code = EXC_OV;
        end else if (i_exc_vec[EXB_ADDR_DATA]) begin
            o_code = i_is_store ? EXC_ADES : EXC_ADEL;
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// Exception / ERET controller at the commit stage. Takes one event per
// sequence, strobes CP0, flushes the pipeline and redirects fetch.
// Optional build macro: EXCEPT_CTRL_INT_SYNC_EN adds a 2-flop synchronizer
// on the external interrupt lines feeding CP0.
module except_ctrl
    import exc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_commit_valid,
    input  logic [31:0] i_commit_pc,
    input  logic        i_commit_in_delay_slot,
    input  logic [5:0]  i_exc_vec,
    input  logic        i_exc_is_store,
    input  logic        i_commit_eret,
    input  logic [5:0]  i_int,
    input  logic        i_timer_int,
    input  logic [31:0] i_status_reg,
    input  logic [31:0] i_cause_reg,
    input  logic [31:0] i_epc_reg,
    input  logic        i_fetch_ready,
    output logic [5:0]  o_cp0_int,
    output logic        o_except_we,
    output logic [4:0]  o_except_cause,
    output logic [31:0] o_current_pc,
    output logic        o_is_in_delay_slot,
    output logic        o_is_eret,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    // ------------------------------------------------------------------
    // Interrupt lines towards CP0 Cause.IP[7:2]
    // ------------------------------------------------------------------
    logic [5:0] int_src;

`ifdef EXCEPT_CTRL_INT_SYNC_EN
    logic [5:0] int_meta_q;
    logic [5:0] int_sync_q;

    // Two-stage synchronizer for asynchronous external interrupt pins
    always_ff @(posedge clk) begin
        if (reset) begin
            int_meta_q <= '0;
            int_sync_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            int_meta_q <= i_int;
            int_sync_q <= int_meta_q;
        end
    end

    assign int_src = int_sync_q;
`else
    assign int_src = i_int;
`endif

    // The timer shares the top hardware interrupt line, as in MIPS32 CP0
    assign o_cp0_int = {int_src[5] | i_timer_int, int_src[4:0]};

    // ------------------------------------------------------------------
    // Event detection
    // ------------------------------------------------------------------
    logic       irq_pending;
    logic       exc_valid;
    logic [4:0] exc_code;
    logic       unused_cp0_bits;

    assign irq_pending = int_pending(i_cause_reg[15:8], i_status_reg[15:8],
                                     i_status_reg[0], i_status_reg[1]);

    // Only IP/IM/IE/EXL matter here; the remaining CP0 bits are ignored
    assign unused_cp0_bits = ^{i_cause_reg[31:16], i_cause_reg[7:0],
                               i_status_reg[31:16], i_status_reg[7:2]};

    exc_priority_enc u_prio (
        .i_exc_vec     (i_exc_vec),
        .i_int_pending (irq_pending),
        .i_is_store    (i_exc_is_store),
        .o_valid       (exc_valid),
        .o_code        (exc_code)
    );

    // ------------------------------------------------------------------
    // Sequence state and captured event data
    // ------------------------------------------------------------------
    exc_state_e  state_q,  state_d;
    event_kind_e kind_q,   kind_d;
    logic [4:0]  cause_q,  cause_d;
    logic [31:0] pc_q,     pc_d;
    logic        ds_q,     ds_d;
    logic [31:0] target_q, target_d;

    // State register and event capture; synchronous reset abandons any sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            kind_q   <= EV_EXC;
            cause_q  <= '0;
            pc_q     <= '0;
            ds_q     <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            ds_q     <= ds_d;
            target_q <= target_d;
        end
    end

    // Next-state, capture and output decode for the IDLE/FLUSH/REDIRECT sequence
    always_comb begin
        state_d            = state_q;
        kind_d             = kind_q;
        cause_d            = cause_q;
        pc_d               = pc_q;
        ds_d               = ds_q;
        target_d           = target_q;
        o_except_we        = 1'b0;
        o_is_eret          = 1'b0;
        o_flush            = 1'b0;
        o_redirect_valid   = 1'b0;
        o_except_cause     = cause_q;
        o_current_pc       = pc_q;
        o_is_in_delay_slot = ds_q;
        o_redirect_pc      = target_q;

        unique case (state_q)
            IDLE: begin
                if (i_commit_valid) begin
                    if (exc_valid) begin
                        // Exceptions win over a simultaneous ERET
                        kind_d   = EV_EXC;
                        cause_d  = exc_code;
                        pc_d     = i_commit_pc;
                        ds_d     = i_commit_in_delay_slot;
                        target_d = EXC_VECTOR;
                        state_d  = FLUSH;
                    end else if (i_commit_eret) begin
                        kind_d   = EV_ERET;
                        target_d = i_epc_reg;
                        state_d  = FLUSH;
                    end
                end
            end
            FLUSH: begin
                o_flush     = 1'b1;
                o_except_we = (kind_q == EV_EXC);
                o_is_eret   = (kind_q == EV_ERET);
                state_d     = REDIRECT;
            end
            REDIRECT: begin
                o_flush          = 1'b1;
                o_redirect_valid = 1'b1;
                if (i_fetch_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are quiet for the whole reset window, not only after the first edge
        if (reset) begin
            o_except_we        = 1'b0;
            o_is_eret          = 1'b0;
            o_flush            = 1'b0;
            o_redirect_valid   = 1'b0;
            o_except_cause     = '0;
            o_current_pc       = '0;
            o_is_in_delay_slot = 1'b0;
            o_redirect_pc      = '0;
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl.
module tb_except_ctrl;

    logic        clk;
    logic        reset;
    logic        i_commit_valid;
    logic [31:0] i_commit_pc;
    logic        i_commit_in_delay_slot;
    logic [5:0]  i_exc_vec;
    logic        i_exc_is_store;
    logic        i_commit_eret;
    logic [5:0]  i_int;
    logic        i_timer_int;
    logic [31:0] i_status_reg;
    logic [31:0] i_cause_reg;
    logic [31:0] i_epc_reg;
    logic        i_fetch_ready;
    logic [5:0]  o_cp0_int;
    logic        o_except_we;
    logic [4:0]  o_except_cause;
    logic [31:0] o_current_pc;
    logic        o_is_in_delay_slot;
    logic        o_is_eret;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    int errors = 0;
    int checks = 0;

    except_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .i_commit_valid         (i_commit_valid),
        .i_commit_pc            (i_commit_pc),
        .i_commit_in_delay_slot (i_commit_in_delay_slot),
        .i_exc_vec              (i_exc_vec),
        .i_exc_is_store         (i_exc_is_store),
        .i_commit_eret          (i_commit_eret),
        .i_int                  (i_int),
        .i_timer_int            (i_timer_int),
        .i_status_reg           (i_status_reg),
        .i_cause_reg            (i_cause_reg),
        .i_epc_reg              (i_epc_reg),
        .i_fetch_ready          (i_fetch_ready),
        .o_cp0_int              (o_cp0_int),
        .o_except_we            (o_except_we),
        .o_except_cause         (o_except_cause),
        .o_current_pc           (o_current_pc),
        .o_is_in_delay_slot     (o_is_in_delay_slot),
        .o_is_eret              (o_is_eret),
        .o_flush                (o_flush),
        .o_redirect_valid       (o_redirect_valid),
        .o_redirect_pc          (o_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_event();
        i_commit_valid         = 1'b0;
        i_commit_pc            = 32'h0;
        i_commit_in_delay_slot = 1'b0;
        i_exc_vec              = 6'b0;
        i_exc_is_store         = 1'b0;
        i_commit_eret          = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".we"},    {31'b0, o_except_we},      32'd0);
        check({tag, ".eret"},  {31'b0, o_is_eret},        32'd0);
        check({tag, ".flush"}, {31'b0, o_flush},          32'd0);
        check({tag, ".rv"},    {31'b0, o_redirect_valid}, 32'd0);
    endtask

    // Issue one exception, check the CP0 strobe cycle, then let it drain
    task automatic run_exc(input string tag, input logic [5:0] vec, input logic store,
                           input logic [31:0] pc, input logic [4:0] exp_code);
        i_commit_valid = 1'b1;
        i_commit_pc    = pc;
        i_exc_vec      = vec;
        i_exc_is_store = store;
        step();
        clear_event();
        check({tag, ".we"},    {31'b0, o_except_we}, 32'd1);
        check({tag, ".cause"}, {27'b0, o_except_cause}, {27'b0, exp_code});
        check({tag, ".pc"},    o_current_pc, pc);
        step();
        check({tag, ".rpc"},   o_redirect_pc, 32'hBFC0_0380);
        step();
        check_quiet({tag, ".done"});
    endtask

    initial begin
        reset         = 1'b1;
        clear_event();
        i_int         = 6'b0;
        i_timer_int   = 1'b0;
        i_status_reg  = 32'h0000_FF01;
        i_cause_reg   = 32'h0;
        i_epc_reg     = 32'h0;
        i_fetch_ready = 1'b1;

        // Reset state, with an event presented to prove it is ignored
        i_commit_valid = 1'b1;
        i_exc_vec      = 6'b010000;
        step();
        step();
        check_quiet("rst");
        check("rst.rpc",   o_redirect_pc, 32'h0);
        check("rst.cause", {27'b0, o_except_cause}, 32'h0);
        clear_event();

        // Interrupt lines to CP0 (settled over 3 cycles to cover the synchronizer build)
        i_int       = 6'b000101;
        i_timer_int = 1'b1;
        step(); step(); step();
        check("cp0int.a", {26'b0, o_cp0_int}, {26'b0, 6'b100101});
        i_int       = 6'b100010;
        i_timer_int = 1'b0;
        step(); step(); step();
        check("cp0int.b", {26'b0, o_cp0_int}, {26'b0, 6'b100010});
        i_int = 6'b0;

        reset = 1'b0;
        step();
        check_quiet("idle");

        // Overflow: full sequence timing
        i_commit_valid = 1'b1;
        i_commit_pc    = 32'h8000_1000;
        i_exc_vec      = 6'b010000;
        step();
        clear_event();
        check("ov.we",    {31'b0, o_except_we}, 32'd1);
        check("ov.cause", {27'b0, o_except_cause}, 32'h0C);
        check("ov.pc",    o_current_pc, 32'h8000_1000);
        check("ov.flush", {31'b0, o_flush}, 32'd1);
        check("ov.rv0",   {31'b0, o_redirect_valid}, 32'd0);
        check("ov.eret",  {31'b0, o_is_eret}, 32'd0);
        step();
        check("ov.we1",   {31'b0, o_except_we}, 32'd0);
        check("ov.rv",    {31'b0, o_redirect_valid}, 32'd1);
        check("ov.rpc",   o_redirect_pc, 32'hBFC0_0380);
        check("ov.flush2", {31'b0, o_flush}, 32'd1);
        step();
        check_quiet("ov.end");

        // Interrupt beats RI; delay-slot flag and PC passed unmodified
        i_cause_reg            = 32'h0000_0400;
        i_commit_valid         = 1'b1;
        i_commit_pc            = 32'h8000_0010;
        i_commit_in_delay_slot = 1'b1;
        i_exc_vec              = 6'b000010;
        step();
        clear_event();
        i_cause_reg = 32'h0;
        check("int.we",    {31'b0, o_except_we}, 32'd1);
        check("int.cause", {27'b0, o_except_cause}, 32'h00);
        check("int.ds",    {31'b0, o_is_in_delay_slot}, 32'd1);
        check("int.pc",    o_current_pc, 32'h8000_0010);
        step(); step();
        check_quiet("int.end");

        // Priority table
        run_exc("p.adelf_ri", 6'b000011, 1'b0, 32'h8000_0100, 5'h04);
        run_exc("p.ri_sys",   6'b000110, 1'b0, 32'h8000_0104, 5'h0A);
        run_exc("p.sys_bp",   6'b001100, 1'b0, 32'h8000_0108, 5'h08);
        run_exc("p.bp_ov",    6'b011000, 1'b0, 32'h8000_010C, 5'h09);
        run_exc("p.ov_ades",  6'b110000, 1'b1, 32'h8000_0110, 5'h0C);
        run_exc("p.ades",     6'b100000, 1'b1, 32'h8000_0114, 5'h05);
        run_exc("p.adel",     6'b100000, 1'b0, 32'h8000_0118, 5'h04);

        // ERET: target is EPC sampled on the accept cycle
        i_epc_reg      = 32'h8000_2004;
        i_commit_valid = 1'b1;
        i_commit_eret  = 1'b1;
        step();
        clear_event();
        i_epc_reg = 32'h1234_5678;
        check("eret.pulse", {31'b0, o_is_eret}, 32'd1);
        check("eret.we",    {31'b0, o_except_we}, 32'd0);
        check("eret.flush", {31'b0, o_flush}, 32'd1);
        step();
        check("eret.pulse1", {31'b0, o_is_eret}, 32'd0);
        check("eret.we1",    {31'b0, o_except_we}, 32'd0);
        check("eret.rv",     {31'b0, o_redirect_valid}, 32'd1);
        check("eret.rpc",    o_redirect_pc, 32'h8000_2004);
        step();
        check_quiet("eret.end");

        // Exception plus simultaneous ERET: exception wins, no ERET strobe
        i_commit_valid = 1'b1;
        i_commit_eret  = 1'b1;
        i_commit_pc    = 32'h8000_0200;
        i_exc_vec      = 6'b001000;
        step();
        clear_event();
        check("exeret.we",    {31'b0, o_except_we}, 32'd1);
        check("exeret.eret",  {31'b0, o_is_eret}, 32'd0);
        check("exeret.cause", {27'b0, o_except_cause}, 32'h09);
        step();
        check("exeret.rpc",   o_redirect_pc, 32'hBFC0_0380);
        step();

        // Backpressure: redirect held stable, new events ignored meanwhile
        i_fetch_ready  = 1'b0;
        i_commit_valid = 1'b1;
        i_commit_pc    = 32'h8000_3000;
        i_exc_vec      = 6'b000100;
        step();
        check("bp.cause", {27'b0, o_except_cause}, 32'h08);
        i_commit_eret = 1'b1;
        i_exc_vec     = 6'b000010;
        i_epc_reg     = 32'h8000_7777;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp.rv",   {31'b0, o_redirect_valid}, 32'd1);
            check("bp.rpc",  o_redirect_pc, 32'hBFC0_0380);
            check("bp.flush", {31'b0, o_flush}, 32'd1);
            check("bp.we",   {31'b0, o_except_we}, 32'd0);
            check("bp.eret", {31'b0, o_is_eret}, 32'd0);
            step();
        end
        check("bp.cause_hold", {27'b0, o_except_cause}, 32'h08);
        i_fetch_ready = 1'b1;
        step();
        check_quiet("bp.handshake");
        clear_event();
        step();
        check_quiet("bp.after");

        // EXL masks a pending interrupt; IE=0 masks it too
        i_status_reg   = 32'h0000_FF03;
        i_cause_reg    = 32'h0000_0400;
        i_commit_valid = 1'b1;
        step();
        check_quiet("exl");
        i_status_reg = 32'h0000_FF00;
        step();
        check_quiet("ie0");
        i_status_reg = 32'h0000_FF01;
        i_cause_reg  = 32'h0;
        clear_event();

        // No commit: exception flags alone must not start a sequence
        i_exc_vec = 6'b010000;
        step();
        check_quiet("nocommit");
        clear_event();

        // Reset in FLUSH abandons the sequence without a redirect
        i_commit_valid = 1'b1;
        i_commit_pc    = 32'h8000_4000;
        i_exc_vec      = 6'b010000;
        step();
        clear_event();
        check("mid.flush_pre", {31'b0, o_flush}, 32'd1);
        reset = 1'b1;
        #1;
        check_quiet("mid.during");
        step();
        check_quiet("mid.rst");
        check("mid.rpc", o_redirect_pc, 32'h0);
        reset = 1'b0;
        step();
        check_quiet("mid.after1");
        step();
        check_quiet("mid.after2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
